// File: rtl/palindrome_serializer_pkg.sv
// pal_pkg: shared definitions for the palindrome serializer.
//   state_t  - FSM state encoding (IDLE / SEND_FWD / SEND_MIR)
//   half_of  - number of free bits in a BITS-long palindrome
package pal_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_FWD = 2'd1,
    SEND_MIR = 2'd2
  } state_t;

  // Free bits per word; for odd lengths the middle bit is counted once.
  function automatic int half_of(input int bits);
    return (bits + 1) / 2;
  endfunction

endpackage

// File: rtl/palindrome_serializer_if.sv
// palindrome_serializer_if: word input handshake plus serial output stream.
//   din/din_valid/din_ready                 - half-word in, valid/ready
//   out/out_valid/out_ready/out_first/out_last - serial bit stream out
//   master modport: the side feeding words and sinking bits
//   slave  modport: the serializer itself
interface palindrome_serializer_if #(
  parameter int BITS = 10
);
  import pal_pkg::*;

  localparam int HALF = half_of(BITS);

  logic [HALF-1:0] din;
  logic            din_valid;
  logic            din_ready;
  logic            out;
  logic            out_valid;
  logic            out_ready;
  logic            out_first;
  logic            out_last;

  modport master (
    output din, din_valid, out_ready,
    input  din_ready, out, out_valid, out_first, out_last
  );

  modport slave (
    input  din, din_valid, out_ready,
    output din_ready, out, out_valid, out_first, out_last
  );

endinterface

// File: rtl/palindrome_serializer_mirror_stack.sv
// pal_mirror_stack: DEPTH-deep 1-bit LIFO holding the forward half of the
// word so the mirrored half can be replayed in reverse order.
//   clk, reset - clock, synchronous active-low reset (clears contents)
//   push, din  - push din onto the stack
//   pop        - discard the top entry
//   top        - current top entry (0 when empty)
module pal_mirror_stack #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic top
);

  // One spare slot above DEPTH keeps the shift slices legal for DEPTH=1.
  logic [DEPTH:0] mem;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem <= '0;
    end else if (push) begin
      mem <= {mem[DEPTH-1:0], din};
    end else if (pop) begin
      mem <= {1'b0, mem[DEPTH:1]};
    end
  end

  assign top = mem[0];

endmodule

// File: rtl/palindrome_serializer.sv
// palindrome_serializer: accepts HALF free bits and transmits them as a
// BITS-long palindrome, MSB of din first, one bit per consumed cycle.
//   clk   - single clock, rising edge
//   reset - synchronous active-low reset
//   bus   - slave side of palindrome_serializer_if (word in, bits out)
module palindrome_serializer
  import pal_pkg::*;
#(
  parameter int BITS = 10
) (
  input logic                   clk,
  input logic                   reset,
  palindrome_serializer_if.slave bus
);

  localparam int HALF = half_of(BITS);
  localparam int CW   = $clog2(BITS);
  localparam logic [CW-1:0] LAST_IDX = CW'(BITS - 1);
  localparam logic [CW-1:0] MID_IDX  = CW'(HALF - 1);
  localparam bit ODD = (BITS % 2) == 1;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   idx_q;
  logic [HALF-1:0] fwd_q;
  logic            consume;
  logic            accept;
  logic            at_mid;
  logic            at_last;
  logic            push;
  logic            pop;
  logic            stack_top;

  assign consume = bus.out_valid & bus.out_ready;
  assign accept  = bus.din_valid & bus.din_ready;
  assign at_mid  = (idx_q == MID_IDX);
  assign at_last = (idx_q == LAST_IDX);

  // The middle bit of an odd word is sent once, so it is never pushed.
  assign push = (state_q == SEND_FWD) && consume && !(ODD && at_mid);
  assign pop  = (state_q == SEND_MIR) && consume;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = SEND_FWD;
      SEND_FWD: if (consume && at_mid) state_d = SEND_MIR;
      SEND_MIR: if (consume && at_last) state_d = accept ? SEND_FWD : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.din_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.out       = 1'b0;
    bus.out_first = 1'b0;
    bus.out_last  = 1'b0;
    case (state_q)
      IDLE: bus.din_ready = reset;
      SEND_FWD: begin
        bus.out_valid = 1'b1;
        bus.out       = fwd_q[HALF-1];
        bus.out_first = (idx_q == '0);
        bus.out_last  = at_last;
      end
      SEND_MIR: begin
        bus.out_valid = 1'b1;
        bus.out       = stack_top;
        bus.out_first = (idx_q == '0);
        bus.out_last  = at_last;
        // Next word may load while the final bit leaves, giving no gap.
        bus.din_ready = reset & at_last & bus.out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q <= '0;
      fwd_q <= '0;
    end else begin
      if (consume) begin
        idx_q <= at_last ? '0 : idx_q + 1'b1;
      end
      if (accept) begin
        fwd_q <= bus.din;
      end else if (state_q == SEND_FWD && consume) begin
        fwd_q <= fwd_q << 1;
      end
    end
  end

  pal_mirror_stack #(
    .DEPTH(HALF)
  ) u_stack (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (fwd_q[HALF-1]),
    .top  (stack_top)
  );

endmodule

// File: tb/tb_palindrome_serializer.sv
// Testbench for palindrome_serializer: one BITS=10 and one BITS=5 instance
// driven with directed words; outputs sampled on the falling clock edge.
module tb_palindrome_serializer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  palindrome_serializer_if #(.BITS(10)) if10 ();
  palindrome_serializer_if #(.BITS(5))  if5 ();

  palindrome_serializer #(.BITS(10)) dut10 (.clk(clk), .reset(reset), .bus(if10));
  palindrome_serializer #(.BITS(5))  dut5  (.clk(clk), .reset(reset), .bus(if5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [4:0] obs;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    obs = {if10.out_valid, if10.out, if10.out_first, if10.out_last, if10.din_ready};
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset10: got %b expected %b", obs, 5'b0);
    end
    obs = {if5.out_valid, if5.out, if5.out_first, if5.out_last, if5.din_ready};
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset5: got %b expected %b", obs, 5'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    obs = {if10.out_valid, if10.din_ready, if5.out_valid, if5.din_ready, 1'b0};
    n_checks++;
    if (obs !== 5'b01010) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", obs, 5'b01010);
    end
  endtask

  task automatic test_basic();
    logic [9:0] exp;
    logic [3:0] obs;
    logic [3:0] expv;
    exp = 10'b1011001101;
    n_checks++;
    if (if10.din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready: got %b expected 1", if10.din_ready);
    end
    if10.din = 5'b10110;
    if10.din_valid = 1'b1;
    @(negedge clk);
    if10.din_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      obs  = {if10.out_valid, if10.out, if10.out_first, if10.out_last};
      expv = {1'b1, exp[9-i], i == 0, i == 9};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL basic bit %0d: got %b expected %b", i, obs, expv);
      end
      @(negedge clk);
    end
    obs  = {if10.out_valid, if10.out, if10.out_first, if10.din_ready};
    n_checks++;
    if (obs !== 4'b0001) begin
      n_fail++;
      $display("FAIL basic_idle: got %b expected %b", obs, 4'b0001);
    end
  endtask

  task automatic test_odd();
    logic [4:0] exp;
    logic [4:0] obs;
    logic [4:0] expv;
    exp = 5'b11011;
    if5.din = 3'b110;
    if5.din_valid = 1'b1;
    @(negedge clk);
    if5.din_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      obs  = {if5.out_valid, if5.out, if5.out_first, if5.out_last, if5.din_ready};
      expv = {1'b1, exp[4-i], i == 0, i == 4, i == 4};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL odd bit %0d: got %b expected %b", i, obs, expv);
      end
      @(negedge clk);
    end
    obs  = {if5.out_valid, if5.out, if5.out_first, if5.out_last, if5.din_ready};
    n_checks++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL odd_idle: got %b expected %b", obs, 5'b00001);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp;
    logic [4:0]  obs;
    logic [4:0]  expv;
    exp = 20'b1000000001_0000110000;
    if10.din = 5'b10000;
    if10.din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      obs  = {if10.out_valid, if10.out, if10.out_first, if10.out_last, if10.din_ready};
      expv = {1'b1, exp[19-i], (i % 10) == 0, (i % 10) == 9, i == 9 || i == 19};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL b2b bit %0d: got %b expected %b", i, obs, expv);
      end
      if (i == 0) if10.din = 5'b00001;
      if (i == 10) if10.din_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (if10.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got out_valid=%b expected 0", if10.out_valid);
    end
  endtask

  task automatic test_stall();
    logic [9:0] exp;
    logic [3:0] obs;
    logic [3:0] expv;
    int         b;
    exp = 10'b1011001101;
    if10.out_ready = 1'b1;
    if10.din = 5'b10110;
    if10.din_valid = 1'b1;
    @(negedge clk);
    if10.din_valid = 1'b0;
    for (int c = 0; c < 13; c++) begin
      b = (c < 4) ? c : ((c <= 7) ? 4 : c - 3);
      obs  = {if10.out_valid, if10.out, if10.out_first, if10.out_last};
      expv = {1'b1, exp[9-b], b == 0, b == 9};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL stall cycle %0d: got %b expected %b", c, obs, expv);
      end
      if10.out_ready = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (if10.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_span: got out_valid=%b expected 0", if10.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp;
    logic [4:0] obs;
    logic [4:0] expv;
    exp = 10'b1011001101;
    if10.din = 5'b10110;
    if10.din_valid = 1'b1;
    @(negedge clk);
    if10.din_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      obs  = {if10.out_valid, if10.out, if10.out_first, if10.out_last, 1'b0};
      expv = {1'b1, exp[9-c], c == 0, 1'b0, 1'b0};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL rstmid bit %0d: got %b expected %b", c, obs, expv);
      end
      if (c == 6) reset = 1'b0;
      @(negedge clk);
    end
    for (int c = 0; c < 2; c++) begin
      obs = {if10.out_valid, if10.out, if10.out_first, if10.out_last, if10.din_ready};
      n_checks++;
      if (obs !== 5'b0) begin
        n_fail++;
        $display("FAIL rstmid_abort %0d: got %b expected %b", c, obs, 5'b0);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    if10.din = 5'b11111;
    if10.din_valid = 1'b1;
    @(negedge clk);
    if10.din_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      obs  = {if10.out_valid, if10.out, if10.out_first, if10.out_last, 1'b0};
      expv = {1'b1, 1'b1, i == 0, i == 9, 1'b0};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL rstmid_new bit %0d: got %b expected %b", i, obs, expv);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy();
    logic [9:0] exp;
    logic [4:0] obs;
    logic [4:0] expv;
    exp = 10'b1011001101;
    if10.din = 5'b10110;
    if10.din_valid = 1'b1;
    @(negedge clk);
    if10.din_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      obs  = {if10.out_valid, if10.out, if10.out_first, if10.out_last, if10.din_ready};
      expv = {1'b1, exp[9-c], c == 0, c == 9, c == 9};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL busy bit %0d: got %b expected %b", c, obs, expv);
      end
      if (c == 2) begin
        if10.din = 5'b01001;
        if10.din_valid = 1'b1;
      end
      if (c == 5) if10.din_valid = 1'b0;
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      obs = {if10.out_valid, if10.out, if10.out_first, if10.out_last, if10.din_ready};
      n_checks++;
      if (obs !== 5'b00001) begin
        n_fail++;
        $display("FAIL idle_din %0d: got %b expected %b", c, obs, 5'b00001);
      end
      if10.din = (c == 1) ? 5'b11111 : 5'b00000;
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    if10.din = '0;
    if10.din_valid = 1'b0;
    if10.out_ready = 1'b1;
    if5.din = '0;
    if5.din_valid = 1'b0;
    if5.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_odd();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/palindrome_serializer.md
PALINDROME_SERIALIZER -- requirements
Module: palindrome_serializer

Interface
REQ-001 The block SHALL have parameter BITS, default 10, giving the transmitted palindrome length in bits; legal values are 2..64.
REQ-002 The block SHALL define localparam HALF = (BITS+1)/2, the number of free bits per word.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 din  input  HALF  first half of the word; din[HALF-1] is transmitted first.
REQ-006 din_valid  input  1  din is valid this cycle.
REQ-007 din_ready  output  1  block accepts din this cycle.
REQ-008 out  output  1  serial bit, valid when out_valid=1; drives a palindrome_detector-style receiver.
REQ-009 out_valid  output  1  out carries a stream bit.
REQ-010 out_ready  input  1  sink consumes out this cycle; a detector-style sink ties it high.
REQ-011 out_first  output  1  current bit is bit 0 of a word.
REQ-012 out_last  output  1  current bit is bit BITS-1 of a word.

Function
REQ-013 A word SHALL be accepted on a rising edge with din_valid=1 and din_ready=1.
REQ-014 Stream bit s_i SHALL equal din[HALF-1-i] for i<HALF, and s_{BITS-1-i} for i>=HALF. For odd BITS, the middle bit SHALL be sent once.
REQ-015 The bit s_i SHALL advance to s_{i+1} only on an edge with out_valid=1 and out_ready=1. While out_ready=0, out, out_first and out_last SHALL hold.
REQ-016 The block SHALL use FSM states IDLE, SEND_FWD (i<HALF) and SEND_MIR (i>=HALF).
- IDLE->SEND_FWD on accept.
- SEND_FWD->SEND_MIR after s_{HALF-1} is consumed.
- SEND_MIR->IDLE after s_{BITS-1} is consumed with no accept.
- SEND_MIR->SEND_FWD after s_{BITS-1} is consumed with a simultaneous accept.
REQ-017 din_ready SHALL be 1 in IDLE, and in SEND_MIR while out_last=1 and out_ready=1; otherwise it SHALL be 0.
REQ-018 Latency SHALL be one cycle: s_0 appears with out_valid=1 on the cycle after accept.
REQ-019 Back-to-back words SHALL stream with no gap cycle when din_valid stays high and out_ready=1. The word period SHALL be exactly BITS cycles.
REQ-020 out_valid SHALL be 1 exactly in SEND_FWD and SEND_MIR. out, out_first and out_last SHALL be 0 whenever out_valid=0.
REQ-021 The bit index counter SHALL be $clog2(BITS) bits wide and SHALL never exceed BITS-1.
REQ-022 In IDLE, din changes with din_valid=0 SHALL have no effect.

Reset
REQ-023 When reset=0 at an edge, the FSM SHALL go to IDLE and the counter and storage SHALL clear.
REQ-024 After such an edge, out=0, out_valid=0, out_first=0, out_last=0 and din_ready=0 (forced low while reset=0).
REQ-025 A reset mid-word SHALL abort the word with no further bits emitted.
REQ-026 On the first edge with reset=1, din_ready=1.

Structure
REQ-027 Package pal_pkg SHALL hold the FSM state encoding constants (IDLE=2'd0, SEND_FWD=2'd1, SEND_MIR=2'd2) and the HALF computation function.
REQ-028 A single sub-module, pal_mirror_stack, SHALL implement a HALF-deep 1-bit LIFO.
- Bits are pushed in SEND_FWD.
- Bits are popped in SEND_MIR; for odd BITS, the middle bit is not pushed.
REQ-029 Top level SHALL contain the FSM, the HALF-bit forward shift register and the counter.

Verification
REQ-030 BITS=10, din=5'b10110, out_ready=1 -> out sequence 1,0,1,1,0,0,1,1,0,1 on cycles 1..10 after accept; out_first on cycle 1, out_last on cycle 10.
REQ-031 BITS=5, din=3'b110 -> out sequence 1,1,0,1,1; din_ready returns to 1 on the cycle after last is consumed.
REQ-032 BITS=10, din_valid held high, words 5'b10000 then 5'b00001 -> 20 contiguous valid bits 1000000001 0000110000, with no gap cycle.
REQ-033 out_ready=0 for 3 cycles at bit 4 -> out, out_first and out_last hold; the sequence resumes unchanged; total span is 13 cycles.
REQ-034 reset=0 at bit 6 of a word -> next cycle out_valid=0 and out=0; after release, a new word 5'b11111 emits ten 1s from s_0.
REQ-035 din_valid=1 while busy mid-word -> din_ready=0 and the word is not captured; the in-flight sequence is unchanged.
